// File: rtl/riscv_muldiv_pkg.sv
// Shared types and op-class decoding for the iterative RV32M/RV64M multiply/divide unit.
package riscv_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_high(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic a_signed(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(input muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/riscv_muldiv_step.sv
// One radix-2 step shared by multiply and divide.
// hi/lo hold {product high, multiplier} for multiply and {remainder, dividend/quotient} for divide.
module muldiv_step
    import riscv_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            div_mode,
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Conditional add-and-shift-right for multiply, trial subtract for restoring divide.
    always_comb begin
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
        shifted = {hi_in, lo_in[XLEN-1]};
        diff    = shifted - {1'b0, operand};
        if (div_mode) begin
            // A clear top bit means no borrow: the divisor fits, quotient bit is 1.
            if (!diff[XLEN]) begin
                hi_out = diff[XLEN-1:0];
                lo_out = {lo_in[XLEN-2:0], 1'b1};
            end else begin
                hi_out = shifted[XLEN-1:0];
                lo_out = {lo_in[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_out = sum[XLEN:1];
            lo_out = {sum[0], lo_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit with start/ready/done handshake.
// Fixed latency: accept, N = XLEN/RADIX_BITS iteration cycles, one fix-up cycle, done pulse.
module riscv_muldiv
    import riscv_muldiv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned RADIX_BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned N  = XLEN / RADIX_BITS;
    localparam int unsigned CW = $clog2(N + 1);

    muldiv_state_t   state, state_next;
    muldiv_op_t      op_in, op_q;
    logic            accept;
    logic [CW-1:0]   count_q, count_next;
    logic [XLEN-1:0] hi_q, lo_q, operand_q, a_raw_q;
    logic            neg_q, neg_r_q, div_zero_q, ovf_q;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] fix_value;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quot_s, rem_s;

    logic [XLEN-1:0] hi_chain [RADIX_BITS+1];
    logic [XLEN-1:0] lo_chain [RADIX_BITS+1];

    assign ready      = (state == ST_IDLE) || (state == ST_DONE);
    assign done       = (state == ST_DONE);
    assign accept     = start & ready;
    assign op_in      = muldiv_op_t'(op);
    assign count_next = count_q - CW'(1);

    // Operand magnitudes and sign flags captured on the accept edge.
    always_comb begin
        a_neg = a_signed(op_in) & a[XLEN-1];
        b_neg = b_signed(op_in) & b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; DONE can accept a new request directly.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_ITER;
            ST_ITER: if (count_next == '0) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = accept ? ST_ITER : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign hi_chain[0] = hi_q;
    assign lo_chain[0] = lo_q;

    for (genvar g = 0; g < RADIX_BITS; g++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .div_mode (is_div(op_q)),
            .hi_in    (hi_chain[g]),
            .lo_in    (lo_chain[g]),
            .operand  (operand_q),
            .hi_out   (hi_chain[g+1]),
            .lo_out   (lo_chain[g+1])
        );
    end

    // Operand capture on accept, RADIX_BITS steps per ITER cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q       <= OP_MUL;
            count_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            operand_q  <= '0;
            a_raw_q    <= '0;
            neg_q      <= 1'b0;
            neg_r_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (accept) begin
            op_q       <= op_in;
            count_q    <= CW'(N);
            hi_q       <= '0;
            lo_q       <= a_mag;
            operand_q  <= b_mag;
            a_raw_q    <= a;
            neg_q      <= a_neg ^ b_neg;
            neg_r_q    <= a_neg;
            div_zero_q <= is_div(op_in) && (b == '0);
            ovf_q      <= is_div(op_in) && a_signed(op_in) &&
                          (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        end else if (state == ST_ITER) begin
            hi_q    <= hi_chain[RADIX_BITS];
            lo_q    <= lo_chain[RADIX_BITS];
            count_q <= count_next;
        end
    end

    // Sign fix-up and special-case selection evaluated during FIX.
    always_comb begin
        prod      = {hi_q, lo_q};
        prod_s    = neg_q ? -prod : prod;
        quot_s    = neg_q ? -lo_q : lo_q;
        rem_s     = neg_r_q ? -hi_q : hi_q;
        fix_value = '0;
        if (!is_div(op_q)) begin
            fix_value = is_high(op_q) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end else if (div_zero_q) begin
            fix_value = is_rem(op_q) ? a_raw_q : '1;
        end else if (ovf_q) begin
            fix_value = is_rem(op_q) ? '0 : a_raw_q;
        end else begin
            fix_value = is_rem(op_q) ? rem_s : quot_s;
        end
    end

    // Result register: written only on FIX edges and cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset)               result <= '0;
        else if (state == ST_FIX) result <= fix_value;
    end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed self-checking bench for riscv_muldiv in two configurations (32/1 and 16/4).
module tb_riscv_muldiv;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        start32 = 1'b0;
    logic [2:0]  op32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        ready32, done32;
    logic [31:0] result32;

    logic        start16 = 1'b0;
    logic [2:0]  op16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ready16, done16;
    logic [15:0] result16;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    riscv_muldiv #(.XLEN(32), .RADIX_BITS(1)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .ready(ready32), .done(done32), .result(result32)
    );

    riscv_muldiv #(.XLEN(16), .RADIX_BITS(4)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
        .ready(ready16), .done(done16), .result(result16)
    );

    typedef struct {
        bit          use16;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          exp_lat;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        else passed++;
    endtask

    function automatic logic cur_done(input bit use16);
        return use16 ? done16 : done32;
    endfunction

    function automatic logic cur_ready(input bit use16);
        return use16 ? ready16 : ready32;
    endfunction

    function automatic logic [31:0] cur_result(input bit use16);
        return use16 ? {16'h0, result16} : result32;
    endfunction

    task automatic drive(input bit use16, input logic s, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        if (use16) begin
            start16 = s; op16 = o; a16 = x[15:0]; b16 = y[15:0];
        end else begin
            start32 = s; op32 = o; a32 = x; b32 = y;
        end
    endtask

    // Issue one op, optionally pulse start at sample pulse_at while busy, wait (bounded) for done.
    // lat counts rising edges after the accept edge up to the one that raises done.
    task automatic run_op(input bit use16, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int pulse_at,
                          output logic [31:0] res, output int lat,
                          output bit stable, output bit busy_ok);
        logic [31:0] prev;
        @(negedge clk);
        drive(use16, 1'b1, o, x, y);
        @(posedge clk);
        @(negedge clk);
        drive(use16, 1'b0, o, x, y);
        prev    = cur_result(use16);
        stable  = 1'b1;
        busy_ok = !cur_ready(use16);
        lat     = 0;
        while (!cur_done(use16) && lat < 100) begin
            if (lat == pulse_at) drive(use16, 1'b1, ~o, ~x, 32'h3);
            @(negedge clk);
            drive(use16, 1'b0, o, x, y);
            lat++;
            if (!cur_done(use16)) begin
                if (cur_result(use16) !== prev) stable = 1'b0;
                if (cur_ready(use16)) busy_ok = 1'b0;
            end
        end
        res = cur_result(use16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int          lat, lat2, stray;
        bit          stable, busy_ok;

        vecs[0]  = '{0, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        vecs[1]  = '{0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
        vecs[2]  = '{0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[3]  = '{0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[4]  = '{0, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vecs[5]  = '{0, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vecs[6]  = '{0, 3'b101, 32'd100,      32'd7,        32'd14,       33};
        vecs[7]  = '{0, 3'b111, 32'd100,      32'd7,        32'd2,        33};
        vecs[8]  = '{0, 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 33};
        vecs[9]  = '{0, 3'b110, 32'd5,        32'd0,        32'd5,        33};
        vecs[10] = '{0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
        vecs[11] = '{0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
        vecs[12] = '{0, 3'b011, 32'h12345678, 32'h10,       32'h00000001, 33};
        vecs[13] = '{0, 3'b000, 32'h12345678, 32'h10,       32'h23456780, 33};
        vecs[14] = '{0, 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        vecs[15] = '{0, 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
        vecs[16] = '{0, 3'b111, 32'd7,        32'd0,        32'd7,        33};
        vecs[17] = '{0, 3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 33};
        vecs[18] = '{1, 3'b101, 32'hFFFF,     32'h0003,     32'h5555,     5};
        vecs[19] = '{1, 3'b000, 32'h00FF,     32'h0101,     32'hFFFF,     5};
        vecs[20] = '{1, 3'b100, 32'hFFF9,     32'd2,        32'hFFFD,     5};
        vecs[21] = '{1, 3'b110, 32'hFFF9,     32'd2,        32'hFFFF,     5};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready32",  {31'd0, ready32}, 32'd1);
        check("reset done32",   {31'd0, done32},  32'd0);
        check("reset result32", result32,         32'd0);
        check("reset ready16",  {31'd0, ready16}, 32'd1);
        check("reset result16", {16'd0, result16}, 32'd0);
        reset = 1'b1;

        // Table-driven operations.
        for (int i = 0; i < 22; i++) begin
            run_op(vecs[i].use16, vecs[i].op, vecs[i].a, vecs[i].b, -1, res, lat, stable, busy_ok);
            check($sformatf("vec%0d result", i),  res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d busy", i),    {31'd0, busy_ok}, 32'd1);
            check($sformatf("vec%0d ready at done", i), {31'd0, cur_ready(vecs[i].use16)}, 32'd1);
        end

        // start pulsed during ITER is ignored.
        run_op(0, 3'b000, 32'd7, 32'd3, 5, res, lat, stable, busy_ok);
        check("iter pulse result",  res, 32'd21);
        check("iter pulse latency", lat, 33);
        check("iter pulse stable",  {31'd0, stable}, 32'd1);

        // start held through DONE: back-to-back accept.
        @(negedge clk);
        drive(0, 1'b1, 3'b000, 32'd6, 32'd7);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 3'b000, 32'd6, 32'd7);
        lat = 0;
        while (!done32 && lat < 100) begin
            if (lat == 30) drive(0, 1'b1, 3'b101, 32'd100, 32'd7);
            @(negedge clk);
            lat++;
        end
        check("b2b first latency", lat, 33);
        check("b2b first result",  result32, 32'd42);
        @(negedge clk);
        drive(0, 1'b0, 3'b101, 32'd100, 32'd7);
        check("b2b accepted in done", {31'd0, ready32}, 32'd0);
        check("b2b result held",      result32, 32'd42);
        lat2 = 0;
        while (!done32 && lat2 < 100) begin
            @(negedge clk);
            lat2++;
        end
        check("b2b second latency", lat2, 33);
        check("b2b second result",  result32, 32'd14);

        // Reset asserted at ITER cycle 10; start held meanwhile must not be taken.
        @(negedge clk);
        drive(0, 1'b1, 3'b000, 32'd9, 32'd9);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 3'b000, 32'd9, 32'd9);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b1, 3'b000, 32'd9, 32'd9);
        @(negedge clk);
        check("midreset ready",  {31'd0, ready32}, 32'd1);
        check("midreset done",   {31'd0, done32},  32'd0);
        check("midreset result", result32,         32'd0);
        @(negedge clk);
        check("start ignored in reset", {31'd0, ready32}, 32'd1);
        drive(0, 1'b0, 3'b000, 32'd9, 32'd9);
        reset = 1'b1;
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done32) stray++;
        end
        check("midreset no stray done", stray, 0);
        check("midreset result stays",  result32, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
